channel_accum: RTL and testbench

- Sits directly downstream of the dot_channel stage and consumes its (valid, q) pair.
- Sums NUM_PHASES partial dot products for one output pixel/channel, adds a per-channel bias and saturates to `data_len`.
- Emits one result with a single-cycle valid pulse, ready for the output buffer.
- One instance is used per dot channel.

---
 rtl/channel_accum_pkg.sv | 11 +
 rtl/channel_accum_sat_round.sv | 27 ++
 rtl/num_data.v | 15 +
 rtl/channel_accum.sv | 111 +++++++++++
 tb/tb_channel_accum.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/channel_accum_pkg.sv
// Shared constants for the channel accumulator stage.
`include "num_data.v"

package channel_accum_pkg;
  localparam int DATA_LEN = `DATA_LEN;

  localparam logic [1:0] ST_IDLE  = `ACC_ST_IDLE;
  localparam logic [1:0] ST_ACCUM = `ACC_ST_ACCUM;
  localparam logic [1:0] ST_BIAS  = `ACC_ST_BIAS;
  localparam logic [1:0] ST_OUT   = `ACC_ST_OUT;
endpackage

// File: rtl/channel_accum_sat_round.sv
// Combinational W -> DW signed clamp with optional ReLU and a clip flag.
`include "num_data.v"

module sat_round #(
   parameter int W    = 20,
   parameter int DW   = 16,
   parameter bit RELU = 1'b0
) (
   input  logic [W-1:0]  acc,
   output logic [DW-1:0] q,
   output logic          clip
);
   logic fits;

   always_comb begin
      // Value fits when every bit above the result sign bit matches it.
      fits = (acc[W-1:DW-1] == {(W-DW+1){acc[DW-1]}});
      q    = acc[DW-1:0];
      clip = 1'b0;
      if (RELU && acc[W-1]) begin
         q = '0;
      end else if (!fits) begin
         clip = 1'b1;
         q    = acc[W-1] ? `SAT_MIN(DW) : `SAT_MAX(DW);
      end
   end
endmodule

// File: rtl/num_data.v
// Shared datapath width plus accumulator-stage state encodings and saturation bounds.
`ifndef NUM_DATA_V
`define NUM_DATA_V

`define DATA_LEN 16

`define ACC_ST_IDLE  2'd0
`define ACC_ST_ACCUM 2'd1
`define ACC_ST_BIAS  2'd2
`define ACC_ST_OUT   2'd3

`define SAT_MAX(n) {1'b0, {((n)-1){1'b1}}}
`define SAT_MIN(n) {1'b1, {((n)-1){1'b0}}}

`endif

// File: rtl/channel_accum.sv
// Sums NUM_PHASES partial dot products, adds bias, saturates to DATA_LEN.
// Optional ReLU on the result via macro CHANNEL_ACCUM_RELU_EN.
`include "num_data.v"

module channel_accum
  import channel_accum_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int GUARD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [`DATA_LEN-1:0] d,
  input  logic [`DATA_LEN-1:0] bias,
  output logic                 busy,
  output logic                 valid,
  output logic [`DATA_LEN-1:0] q,
  output logic                 ovf
);
  localparam int W = `DATA_LEN + GUARD_BITS;
  localparam logic [2:0] LAST = 3'(NUM_PHASES - 1);
`ifdef CHANNEL_ACCUM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic [1:0]           state_q, state_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 in_valid_prev_q;
  logic                 valid_q, valid_d;
  logic [`DATA_LEN-1:0] q_q, q_d;
  logic                 ovf_q, ovf_d;

  logic                 cap;
  logic [W-1:0]         d_ext, bias_ext;
  logic [`DATA_LEN-1:0] sat_q;
  logic                 sat_clip;

  assign cap      = in_valid & ~in_valid_prev_q;
  assign d_ext    = {{GUARD_BITS{d[`DATA_LEN-1]}}, d};
  assign bias_ext = {{GUARD_BITS{bias[`DATA_LEN-1]}}, bias};

  sat_round #(.W(W), .DW(`DATA_LEN), .RELU(RELU)) u_sat (
    .acc  (acc_q),
    .q    (sat_q),
    .clip (sat_clip)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    q_d     = q_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: if (cap) begin
          acc_d = acc_q + d_ext;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST) state_d = ST_BIAS;
        end
        ST_BIAS: begin
          acc_d   = acc_q + bias_ext;
          state_d = ST_OUT;
        end
        ST_OUT: begin
          q_d     = sat_q;
          valid_d = 1'b1;
          ovf_d   = ovf_q | sat_clip;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      in_valid_prev_q <= 1'b0;
      valid_q         <= 1'b0;
      q_q             <= '0;
      ovf_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      in_valid_prev_q <= in_valid;
      valid_q         <= valid_d;
      q_q             <= q_d;
      ovf_q           <= ovf_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign q     = q_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_channel_accum.sv
// Directed bench for channel_accum with a transaction-level reference model.
module tb_channel_accum;
   localparam int NP = 3;
   localparam int DL = 16;
   localparam int QMAX = 32767;
   localparam int QMIN = -32768;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [DL-1:0] d = '0;
   logic [DL-1:0] bias = '0;
   logic          busy, valid, ovf;
   logic [DL-1:0] q;

   int n_pass = 0;
   int n_total = 0;
   int n_valid = 0;
   int last_q = 0;
   bit cmp_en = 1'b0;

   channel_accum #(.NUM_PHASES(NP), .GUARD_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .d(d), .bias(bias), .busy(busy), .valid(valid), .q(q), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference: a result is the plain sum of the first NP captured rising
   // edges after start, plus bias, clamped to the signed output range.
   bit armed, prev_iv;
   int sum, n_cap, cd;
   int m_q;
   bit m_valid, m_ovf, m_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed = 0; prev_iv = 0; sum = 0; n_cap = 0; cd = 0;
         m_q = 0; m_valid = 0; m_ovf = 0; m_busy = 0;
      end else begin
         m_valid = 0;
         if (start) begin
            armed = 1; sum = 0; n_cap = 0; cd = 0; m_ovf = 0;
         end else if (cd == 2) begin
            sum += int'($signed(bias));
            cd = 1;
         end else if (cd == 1) begin
            m_valid = 1;
            cd = 0;
`ifdef CHANNEL_ACCUM_RELU_EN
            if (sum < 0) m_q = 0;
            else
`endif
            if (sum > QMAX) begin m_q = QMAX; m_ovf = 1; end
            else if (sum < QMIN) begin m_q = QMIN; m_ovf = 1; end
            else m_q = sum;
         end else if (armed && in_valid && !prev_iv) begin
            sum += int'($signed(d));
            n_cap++;
            if (n_cap == NP) begin armed = 0; cd = 2; end
         end
         prev_iv = in_valid;
         m_busy = armed || (cd != 0);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", int'(busy), int'(m_busy));
         chk("valid", int'(valid), int'(m_valid));
         chk("q", int'($signed(q)), m_q);
         chk("ovf", int'(ovf), int'(m_ovf));
      end
      if (valid) begin
         n_valid++;
         last_q = int'($signed(q));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse(input int v);
      d = DL'(v);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
   endtask

   task automatic run3(input int a, input int b, input int c, input int bv);
      bias = DL'(bv);
      pulse(a);
      pulse(b);
      pulse(c);
      repeat (4) step();
   endtask

   initial begin
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_q", int'(q), 0);
      chk("rst_ovf", int'(ovf), 0);
      step();
      rst_n = 1'b1;
      cmp_en = 1'b1;
      step();

      // Basic, with literal latency: valid visible right after edge E+2 only.
      n_valid = 0;
      do_start();
      bias = DL'(7);
      pulse(100);
      pulse(200);
      pulse(-50);
      step();
      chk("basic_lat_on", int'(valid), 1);
      chk("basic_q", int'($signed(q)), 257);
      step();
      chk("basic_lat_off", int'(valid), 0);
      repeat (2) step();
      chk("basic_nvalid", n_valid, 1);
      chk("basic_ovf", int'(ovf), 0);

      // Held level counts once.
      n_valid = 0;
      do_start();
      bias = '0;
      d = DL'(10);
      in_valid = 1'b1;
      repeat (5) step();
      in_valid = 1'b0;
      step();
      pulse(10);
      pulse(10);
      repeat (4) step();
      chk("held_q", last_q, 30);
      chk("held_nvalid", n_valid, 1);

      // Positive and negative saturation; ovf cleared by start.
      do_start();
      run3(30000, 30000, 30000, 0);
      chk("satp_q", int'($signed(q)), 32767);
      chk("satp_ovf", int'(ovf), 1);
      do_start();
      chk("sat_ovf_clr", int'(ovf), 0);
      run3(-30000, -30000, -30000, 0);
      chk("satn_q", int'($signed(q)), -32768);
      chk("satn_ovf", int'(ovf), 1);

      // Restart with a simultaneous capture edge discarded.
      n_valid = 0;
      do_start();
      pulse(5);
      d = DL'(99);
      in_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b0;
      step();
      run3(1, 2, 3, 0);
      chk("restart_q", last_q, 6);
      chk("restart_nvalid", n_valid, 1);

      // start in OUT cancels the pending result.
      n_valid = 0;
      do_start();
      bias = '0;
      pulse(40);
      pulse(40);
      pulse(40);
      do_start();
      chk("cancel_nvalid", n_valid, 0);
      chk("cancel_busy", int'(busy), 1);
      run3(1, 1, 1, 0);
      chk("cancel_q", last_q, 3);

      // Async reset mid-ACCUM.
      n_valid = 0;
      do_start();
      pulse(1);
      pulse(2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_valid", int'(valid), 0);
      chk("arst_q", int'(q), 0);
      chk("arst_ovf", int'(ovf), 0);
      step();
      rst_n = 1'b1;
      run3(5, 5, 5, 0);
      chk("arst_nvalid", n_valid, 0);
      chk("arst_idle", int'(busy), 0);

      // Negative result: ReLU-dependent.
      n_valid = 0;
      do_start();
      run3(-10, -20, 5, 0);
`ifdef CHANNEL_ACCUM_RELU_EN
      chk("relu_q", last_q, 0);
`else
      chk("relu_q", last_q, -25);
`endif
      chk("relu_ovf", int'(ovf), 0);
      chk("relu_nvalid", n_valid, 1);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
